// File: rtl/mod_99_mm_pkg.sv
// Shared encodings for the MAC Merge verify machine: FSM states, verify_status codes
// and the default attempt limit.
package mod_99_mm_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int DEFAULT_VERIFY_LIMIT = 3;

   localparam logic [2:0] ST_INIT     = 3'd0;
   localparam logic [2:0] ST_IDLE     = 3'd1;
   localparam logic [2:0] ST_SEND     = 3'd2;
   localparam logic [2:0] ST_WAIT     = 3'd3;
   localparam logic [2:0] ST_VERIFIED = 3'd4;
   localparam logic [2:0] ST_FAIL     = 3'd5;

   localparam logic [2:0] VS_DISABLED   = 3'd0;
   localparam logic [2:0] VS_INITIAL    = 3'd1;
   localparam logic [2:0] VS_VERIFYING  = 3'd2;
   localparam logic [2:0] VS_SUCCEEDED  = 3'd3;
   localparam logic [2:0] VS_FAILED     = 3'd4;

   // Status implied by the FSM state alone; the DISABLED case is decided by the caller.
   function automatic logic [2:0] status_of(input logic [2:0] st);
      case (st)
         ST_SEND, ST_WAIT: status_of = VS_VERIFYING;
         ST_VERIFIED:      status_of = VS_SUCCEEDED;
         ST_FAIL:          status_of = VS_FAILED;
         default:          status_of = VS_INITIAL;
      endcase
   endfunction

endpackage

// File: rtl/mod_99_verify_timer.sv
// verify_time timer: a TICKS_PER_MS prescaler feeding a millisecond down-counter.
// start (re)loads both counters; done pulses for one cycle when the last ms expires.
module mod_99_verify_timer
   import mod_99_mm_pkg::*;
#(
   parameter int TICKS_PER_MS = 125000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] verify_time,
   output logic       done
);

   localparam int            PW       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
   localparam logic [PW-1:0] PRE_LOAD = PW'(TICKS_PER_MS - 1);

   logic [PW-1:0] pre_cnt;
   logic [7:0]    ms_cnt;
   logic          running;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         ms_cnt  <= '0;
         running <= FALSE;
         done    <= FALSE;
      end else begin
         done <= FALSE;
         if (start) begin
            // verify_time of 0 encodes the 128 ms maximum
            pre_cnt <= PRE_LOAD;
            ms_cnt  <= (verify_time == 7'd0) ? 8'd128 : {1'b0, verify_time};
            running <= TRUE;
         end else if (running) begin
            if (pre_cnt == '0) begin
               pre_cnt <= PRE_LOAD;
               ms_cnt  <= ms_cnt - 8'd1;
               if (ms_cnt == 8'd1) begin
                  done    <= TRUE;
                  running <= FALSE;
               end
            end else begin
               pre_cnt <= pre_cnt - PW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/mod_99_8a_verify.sv
// MAC Merge verify initiator: sends verify mPackets, waits for a respond, reports verified/failed.
// Define VERIFY_STATS_EN to add saturating verify_tx_cnt / respond_rx_cnt statistics outputs.
module mod_99_8a_verify
   import mod_99_mm_pkg::*;
#(
   parameter int TICKS_PER_MS = 125000,
   parameter int VERIFY_LIMIT = DEFAULT_VERIFY_LIMIT,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reset_begin,
   input  logic             p_enable,
   input  logic             disable_verify,
   input  logic             link_fail,
   input  logic [6:0]       verify_time,
   input  logic             rcv_r,
   input  logic             send_v_done,
   output logic             send_v,
   output logic             verified,
   output logic             verify_fail,
   output logic             preempt_active,
   output logic [2:0]       verify_status,
   output logic [2:0]       verify_state
`ifdef VERIFY_STATS_EN
   ,
   output logic [CNT_W-1:0] verify_tx_cnt,
   output logic [CNT_W-1:0] respond_rx_cnt
`endif
);

   if (CNT_W < 1 || VERIFY_LIMIT < 1 || VERIFY_LIMIT > 7) begin : g_param_chk
      $error("mod_99_8a_verify: CNT_W must be >= 1 and VERIFY_LIMIT within 1..7");
   end

   localparam logic [2:0] LIMIT = 3'(VERIFY_LIMIT);

   logic [2:0] state_q, state_d;
   logic [2:0] verify_cnt;
   logic       override;
   logic       timer_start, timer_done;

   assign override = reset_begin | link_fail | ~p_enable | disable_verify;

   always_comb begin
      state_d = state_q;
      if (override) begin
         state_d = ST_INIT;
      end else begin
         case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: if (timer_done) state_d = ST_SEND;
            ST_SEND: if (send_v_done) state_d = ST_WAIT;
            ST_WAIT: begin
               // a respond arriving on the timeout cycle still counts
               if (rcv_r)
                  state_d = ST_VERIFIED;
               else if (timer_done)
                  state_d = (verify_cnt < LIMIT) ? ST_SEND : ST_FAIL;
            end
            ST_VERIFIED, ST_FAIL: state_d = state_q;
            default: state_d = ST_INIT;
         endcase
      end
   end

   assign timer_start = (state_d != state_q) && (state_d == ST_IDLE || state_d == ST_WAIT);

   mod_99_verify_timer #(
      .TICKS_PER_MS (TICKS_PER_MS)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (timer_start),
      .verify_time (verify_time),
      .done        (timer_done)
   );

   // Outputs are registered from the next state so they track verify_state exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_INIT;
         verify_cnt     <= '0;
         send_v         <= FALSE;
         verified       <= FALSE;
         verify_fail    <= FALSE;
         preempt_active <= FALSE;
         verify_status  <= VS_DISABLED;
      end else begin
         state_q <= state_d;
         if (state_d == ST_INIT)
            verify_cnt <= '0;
         else if (state_d == ST_SEND && state_q != ST_SEND)
            verify_cnt <= verify_cnt + 3'd1;
         send_v         <= (state_d == ST_SEND);
         verified       <= (state_d == ST_VERIFIED);
         verify_fail    <= (state_d == ST_FAIL);
         preempt_active <= p_enable & ((state_d == ST_VERIFIED) | disable_verify) & ~link_fail;
         verify_status  <= (~p_enable | disable_verify) ? VS_DISABLED : status_of(state_d);
      end
   end

   assign verify_state = state_q;

`ifdef VERIFY_STATS_EN
   logic tx_accept, rx_accept;

   assign tx_accept = (state_q == ST_SEND) && (state_d == ST_WAIT);
   assign rx_accept = (state_q == ST_WAIT) && (state_d == ST_VERIFIED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         verify_tx_cnt  <= '0;
         respond_rx_cnt <= '0;
      end else begin
         if (tx_accept && verify_tx_cnt != '1)
            verify_tx_cnt <= verify_tx_cnt + CNT_W'(1);
         if (rx_accept && respond_rx_cnt != '1)
            respond_rx_cnt <= respond_rx_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mod_99_8a_verify.sv
// Scoreboard bench for mod_99_8a_verify: the driver predicts send_v/verified/verify_fail events from
// the protocol timing rules; a monitor compares DUT output rises against them. Honours VERIFY_STATS_EN.
module tb_mod_99_8a_verify;

   localparam int T   = 10;
   localparam int LIM = 3;
   localparam int CW  = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       reset_begin = 1'b1;
   logic       p_enable = 1'b1;
   logic       disable_verify = 1'b0;
   logic       link_fail = 1'b0;
   logic [6:0] verify_time = 7'd2;
   logic       rcv_r = 1'b0;
   logic       send_v_done = 1'b0;
   logic       send_v, verified, verify_fail, preempt_active;
   logic [2:0] verify_status, verify_state;
`ifdef VERIFY_STATS_EN
   logic [CW-1:0] verify_tx_cnt, respond_rx_cnt;
`endif

   mod_99_8a_verify #(
      .TICKS_PER_MS (T),
      .VERIFY_LIMIT (LIM),
      .CNT_W        (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .reset_begin    (reset_begin),
      .p_enable       (p_enable),
      .disable_verify (disable_verify),
      .link_fail      (link_fail),
      .verify_time    (verify_time),
      .rcv_r          (rcv_r),
      .send_v_done    (send_v_done),
      .send_v         (send_v),
      .verified       (verified),
      .verify_fail    (verify_fail),
      .preempt_active (preempt_active),
      .verify_status  (verify_status),
      .verify_state   (verify_state)
`ifdef VERIFY_STATS_EN
      ,
      .verify_tx_cnt  (verify_tx_cnt),
      .respond_rx_cnt (respond_rx_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int kind; int at; } ev_t;   // kind 1 send_v, 2 verified, 3 verify_fail
   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  tx_model = 0;
   int  rx_model = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic got(input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event actual kind=%0d at=%0d required none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || cyc < e.at - 1 || cyc > e.at + 1) begin
            failures++;
            $display("FAIL event actual kind=%0d at=%0d required kind=%0d at=%0d",
                     kind, cyc, e.kind, e.at);
         end
      end
   endtask

   logic p_sv = 1'b0, p_vf = 1'b0, p_fl = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (send_v && !p_sv)      got(1);
         if (verified && !p_vf)    got(2);
         if (verify_fail && !p_fl) got(3);
      end
      p_sv <= send_v;
      p_vf <= verified;
      p_fl <= verify_fail;
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic pulse_strays();
      rcv_r = 1'b1;
      send_v_done = 1'b1;
      @(negedge clk);
      rcv_r = 1'b0;
      send_v_done = 1'b0;
   endtask

   task automatic apply_override(input int kind);
      @(negedge clk);
      case (kind)
         0:       reset_begin = 1'b1;
         1:       link_fail = 1'b1;
         default: p_enable = 1'b0;
      endcase
      repeat (2) @(negedge clk);
      chk("ovr_send_v", send_v, 0);
      chk("ovr_verified", verified, 0);
      chk("ovr_verify_fail", verify_fail, 0);
      chk("ovr_state", verify_state, 0);
      chk("ovr_status", verify_status, (kind == 2) ? 0 : 1);
      chk("ovr_preempt", preempt_active, 0);
   endtask

   // Release all overrides and play one verify exchange; resp_at = attempt answered (0 = never).
   task automatic run_verify(input int vt, input int resp_at, input bit coincide, input bit strays);
      int  n, per, prev, s, a, r, d;
      bit  fin;
      n   = (vt == 0) ? 128 : vt;
      per = n * T;
      fin = 1'b0;
      @(negedge clk);
      verify_time    = 7'(vt);
      reset_begin    = 1'b0;
      link_fail      = 1'b0;
      p_enable       = 1'b1;
      disable_verify = 1'b0;
      prev = cyc + 1;
      for (int k = 1; k <= LIM && !fin; k++) begin
         s = prev + per + 1;
         exp_q.push_back('{1, s});
         if (k == 1 && strays) begin
            wait_until(prev + 2);
            pulse_strays();
         end
         d = $urandom_range(2, 6);
         a = s + d;
         wait_until(a - 1);
         send_v_done = 1'b1;
         @(negedge clk);
         send_v_done = 1'b0;
         tx_model++;
         if (k == resp_at) begin
            r = coincide ? (a + per + 1) : (a + $urandom_range(1, per));
            exp_q.push_back('{2, r});
            wait_until(r - 1);
            rcv_r = 1'b1;
            @(negedge clk);
            rcv_r = 1'b0;
            rx_model++;
            if (strays) pulse_strays();
            wait_until(r + 3);
            chk("verified", verified, 1);
            chk("status_succeeded", verify_status, 3);
            chk("preempt_verified", preempt_active, 1);
            chk("state_verified", verify_state, 4);
            fin = 1'b1;
         end else if (k == LIM) begin
            exp_q.push_back('{3, a + per + 1});
            wait_until(a + per + 3);
            if (strays) pulse_strays();
            chk("verify_fail", verify_fail, 1);
            chk("status_failed", verify_status, 4);
            chk("preempt_failed", preempt_active, 0);
            chk("state_fail", verify_state, 5);
            fin = 1'b1;
         end
         prev = a;
      end
      repeat (3) @(negedge clk);
      chk("events_drained", exp_q.size(), 0);
`ifdef VERIFY_STATS_EN
      chk("verify_tx_cnt", int'(verify_tx_cnt), tx_model);
      chk("respond_rx_cnt", int'(respond_rx_cnt), rx_model);
`endif
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      repeat (3) @(negedge clk);
      chk("rst_send_v", send_v, 0);
      chk("rst_verified", verified, 0);
      chk("rst_verify_fail", verify_fail, 0);
      chk("rst_preempt", preempt_active, 0);
      chk("rst_status", verify_status, 0);
      chk("rst_state", verify_state, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // happy path, then link_fail while VERIFIED and a fresh exchange
      run_verify(2, 1, 1'b0, 1'b0);
      apply_override(1);
      run_verify(2, 2, 1'b0, 1'b1);
      // no response: three requests then fail
      apply_override(0);
      run_verify(2, 0, 1'b0, 1'b1);
      // respond on the third timeout cycle
      apply_override(2);
      run_verify(1, 3, 1'b1, 1'b0);
      // verify_time 0 means 128 ms
      apply_override(0);
      run_verify(0, 1, 1'b0, 1'b0);

      for (int i = 0; i < 14; i++) begin
         apply_override(int'($urandom_range(0, 2)));
         run_verify(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
      end

      // disable_verify: no verify traffic, preemption active immediately
      @(negedge clk);
      reset_begin = 1'b0;
      link_fail = 1'b0;
      p_enable = 1'b1;
      disable_verify = 1'b1;
      verify_time = 7'd1;
      repeat (40) @(negedge clk);
      chk("dis_preempt", preempt_active, 1);
      chk("dis_status", verify_status, 0);
      chk("dis_state", verify_state, 0);
      chk("dis_send_v", send_v, 0);

      // asynchronous reset while in SEND_VERIFY
      @(negedge clk);
      disable_verify = 1'b0;
      s0 = cyc + 1 + T + 1;
      exp_q.push_back('{1, s0});
      wait_until(s0 + 1);
      chk("pre_rst_send_v", send_v, 1);
      #2;
      rst_n = 1'b0;
      reset_begin = 1'b1;
      #1;
      chk("arst_send_v", send_v, 0);
      chk("arst_state", verify_state, 0);
      chk("arst_status", verify_status, 0);
      chk("arst_preempt", preempt_active, 0);
      tx_model = 0;
      rx_model = 0;
`ifdef VERIFY_STATS_EN
      chk("arst_tx_cnt", int'(verify_tx_cnt), tx_model);
      chk("arst_rx_cnt", int'(respond_rx_cnt), rx_model);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      run_verify(1, 1, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      chk("final_drained", exp_q.size(), 0);
      $display("model counts tx=%0d rx=%0d", tx_model, rx_model);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
